uart_rx_frame_ctrl: RTL

Receive-side frame controller of the UART RX path. Synchronises the raw serial line, qualifies the start bit with an oversampling tick, and emits one mid-bit sample strobe plus sampled bit per data bit. Its outputs drive the downstream SIPO shift register's `baud_out`, `enable_SIPO` and `rx` inputs. It then checks the stop bit (and optionally parity) and reports frame completion or error.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx_frame_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default frame geometry and a parity helper.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Even parity fails on XOR=1, odd parity fails on XOR=0.
  function automatic logic parity_mismatch(input logic xor_all, input logic odd);
    return xor_all ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; both flops reset to 1 so an idle-high
// line never shows a spurious low edge out of reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start qualification, mid-bit data strobes, stop/parity check.
// Optional parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_16x,
  input  logic rx,
  output logic baud_out,
  output logic enable_SIPO,
  output logic rx_bit,
  output logic busy,
  output logic frame_done,
  output logic frame_error,
  output logic parity_error
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_t     state_reg, state_next;
  logic [OS_W-1:0] os_cnt_reg, os_cnt_next;
  logic [BC_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [1:0]      settle_reg, settle_next;
  logic            armed_reg, armed_next;
  logic            rx_bit_reg, rx_bit_next;
  logic            baud_reg, baud_next;
  logic            enable_reg, enable_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic            perr_reg, perr_next;
  logic            mid_tick;

`ifdef UART_RX_PARITY_EN
  logic par_acc_reg, par_acc_next;
  logic par_err_reg, par_err_next;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  sync_2ff u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign mid_tick = tick_16x && (os_cnt_reg == OS_LAST);

  always_comb begin
    state_next   = state_reg;
    os_cnt_next  = tick_16x ? os_cnt_reg + OS_W'(1) : os_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    settle_next  = (settle_reg == 2'd2) ? settle_reg : settle_reg + 2'd1;
    armed_next   = armed_reg;
    rx_bit_next  = rx_bit_reg;
    baud_next    = 1'b0;
    done_next    = 1'b0;
    err_next     = 1'b0;
    perr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_next = par_acc_reg;
    par_err_next = par_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        os_cnt_next = '0;
        // Arm only on a genuine high once the synchroniser has flushed its reset value,
        // so a line that stays low (break, aborted frame) cannot start a new frame.
        if ((settle_reg == 2'd2) && rx_s) armed_next = 1'b1;
        if (armed_reg && !rx_s) begin
          state_next = START;
          armed_next = 1'b0;
        end
      end
      START: begin
        if (tick_16x && (os_cnt_reg == OS_HALF)) begin
          if (!rx_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
            par_acc_next = 1'b0;
            par_err_next = 1'b0;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (mid_tick) begin
          os_cnt_next  = '0;
          rx_bit_next  = rx_s;
          baud_next    = 1'b1;
          bit_cnt_next = bit_cnt_reg + BC_W'(1);
`ifdef UART_RX_PARITY_EN
          par_acc_next = par_acc_reg ^ rx_s;
          if (bit_cnt_reg == BC_LAST) state_next = PARITY;
`else
          if (bit_cnt_reg == BC_LAST) state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_tick) begin
          par_err_next = parity_mismatch(par_acc_reg ^ rx_s, PARITY_ODD);
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (mid_tick) begin
          done_next  = rx_s;
          err_next   = !rx_s;
`ifdef UART_RX_PARITY_EN
          perr_next  = par_err_reg;
`endif
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state_reg) os_cnt_next = '0;
    // Stays high through the strobe of the last data bit.
    enable_next = (state_next == DATA) || baud_next;
    busy_next   = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      os_cnt_reg  <= '0;
      bit_cnt_reg <= '0;
      settle_reg  <= 2'd0;
      armed_reg   <= 1'b0;
      rx_bit_reg  <= 1'b0;
      baud_reg    <= 1'b0;
      enable_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      perr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      os_cnt_reg  <= os_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      settle_reg  <= settle_next;
      armed_reg   <= armed_next;
      rx_bit_reg  <= rx_bit_next;
      baud_reg    <= baud_next;
      enable_reg  <= enable_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      perr_reg    <= perr_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_acc_reg <= 1'b0;
      par_err_reg <= 1'b0;
    end else begin
      par_acc_reg <= par_acc_next;
      par_err_reg <= par_err_next;
    end
  end
`endif

  assign baud_out     = baud_reg;
  assign enable_SIPO  = enable_reg;
  assign rx_bit       = rx_bit_reg;
  assign busy         = busy_reg;
  assign frame_done   = done_reg;
  assign frame_error  = err_reg;
  assign parity_error = perr_reg;

endmodule
